booth_product_accumulator: RTL
==============================

// Module: booth_product_accumulator
// PURPOSE
//   Downstream consumer of booth_multiplier. Sums a programmed number of signed
//   products into a wider accumulator and presents the result with a valid/ready
//   handshake. This is the accumulate half of a multiply-accumulate datapath.
//   booth_multiplier has no backpressure, so this block never stalls it. Products
//   arriving outside a run are discarded and flagged.
// PARAMETERS
//   WIDTH_PRODUCT  32  width of signed product input (matches multiplier output)
//   WIDTH_ACC      40  width of signed accumulator; must be >= WIDTH_PRODUCT
//   COUNT_WIDTH     8  width of term counter (max 2**COUNT_WIDTH-1 terms per run)
// PORTS
//   clk         in   1              single clock, all logic on rising edge
//   reset       in   1              synchronous, active-low reset
//   start       in   1              pulse; begins a run (accepted in IDLE only)
//   num_terms   in   COUNT_WIDTH    products to sum; sampled with accepted start
//   prod_valid  in   1              one-cycle strobe; connects to multiplier valid_out
//   product     in   WIDTH_PRODUCT  signed product; sampled when prod_valid=1
//   busy        out  1              state != IDLE
//   acc_valid   out  1              result available (state DONE)
//   acc_ready   in   1              consumer accepts result when acc_valid&acc_ready
//   acc_out     out  WIDTH_ACC      signed sum; stable while acc_valid=1
//   overflow    out  1              sticky: signed overflow occurred during this run
//   dropped     out  1              sticky: a product arrived outside ACCUM
// BEHAVIOUR
//   Reset (reset=0 at a clk edge): state=IDLE, remaining=0. All outputs are 0:
//     busy, acc_valid, acc_out, overflow, dropped. Reset applies in any state,
//     including mid-run. The partial sum is lost and no acc_valid is produced.
//   FSM states: IDLE, ACCUM, DONE.
//   IDLE:
//     start=1 and num_terms!=0: go to ACCUM. Clear acc, overflow and dropped.
//       Load remaining=num_terms.
//     start=1 and num_terms==0: go to DONE with acc=0. acc_valid rises next cycle.
//       Clear overflow and dropped.
//   ACCUM:
//     prod_valid=1: acc <= acc + sign_extend(product); remaining <= remaining-1.
//       If remaining==1, go to DONE.
//     prod_valid=0: hold.
//     start is ignored in ACCUM.
//   DONE:
//     acc_valid=1 and acc_out holds the sum. When acc_ready=1, go to IDLE;
//       acc_valid falls next cycle.
//     start is ignored in DONE, including a start in the same cycle as the
//       handshake. start is only acted on in IDLE.
//   Latency: last product sampled at edge N gives acc_valid=1 after edge N.
//     No combinational path from inputs to outputs.
//   Arithmetic: two's complement, WIDTH_ACC bits, wrap on overflow (no saturation).
//     overflow is set if operands of the add share a sign and the sum sign differs.
//     It stays set until the next accepted start or reset.
//   prod_valid=1 in IDLE or DONE: product discarded, acc unchanged, dropped<=1.
//     dropped stays set until the next accepted start or reset.
//   acc_out updates only in ACCUM. It retains its value in IDLE after a handshake.
// TESTING
//   1 Reset; start, num_terms=3; products 100, -50, 7 with gaps of 0-4 cycles
//     -> acc_out=57, acc_valid 1 cycle after 3rd strobe, overflow=0, dropped=0.
//   2 start with num_terms=0
//     -> next cycle acc_valid=1, acc_out=0, busy=1; acc_ready=1 -> IDLE.
//   3 Finish a 2-term run (0x7FFF, -1); hold acc_ready=0 for 5 cycles, pulse
//     prod_valid with 1234, pulse start
//     -> acc_out=0x7FFE stays stable, dropped=1, state remains DONE.
//   4 WIDTH_ACC=33; num_terms=3; three products 0x7FFF_FFFF
//     -> acc_out = -0x8000_0003 (33-bit wrap), overflow=1.
//   5 Run with num_terms=4; assert reset=0 after 2 products
//     -> next cycle busy=0, acc_valid=0, acc_out=0. New 1-term run (-8) gives -8.
//   6 Chain with booth_multiplier: 5 random 16-bit pairs, num_terms=5
//     -> acc_out equals the sum of signed a*b computed by the reference model.

Source files
------------

// File: rtl/booth_product_accumulator.sv
// Accumulates a programmed number of signed products from booth_multiplier into a
// wider two's-complement sum, then offers the sum on a valid/ready handshake.
// The multiplier cannot be stalled, so products arriving outside a run are
// discarded and flagged rather than back-pressured.
module booth_product_accumulator #(
    parameter int unsigned WIDTH_PRODUCT = 32,
    parameter int unsigned WIDTH_ACC     = 40, // must be >= WIDTH_PRODUCT
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   num_terms,
    input  logic                     prod_valid,
    input  logic [WIDTH_PRODUCT-1:0] product,
    output logic                     busy,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [WIDTH_ACC-1:0]     acc_out,
    output logic                     overflow,
    output logic                     dropped
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_ACC-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   overflow_q, overflow_d;
    logic                   dropped_q, dropped_d;

    logic signed [WIDTH_PRODUCT-1:0] product_s;
    logic [WIDTH_ACC-1:0]            product_ext;
    logic [WIDTH_ACC-1:0]            sum;
    logic                            sum_ovf;

    // Sign-extend the product and form the wrapping sum plus its signed-overflow flag
    always_comb begin
        product_s   = product;
        product_ext = WIDTH_ACC'(product_s);
        sum         = acc_q + product_ext;
        // Overflow: both operands share a sign but the result does not.
        sum_ovf     = (acc_q[WIDTH_ACC-1] == product_ext[WIDTH_ACC-1]) &&
                      (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);
    end

    // Next-state logic for the run FSM, accumulator, term counter and sticky flags
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        dropped_d   = dropped_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d       = '0;
                    overflow_d  = 1'b0;
                    dropped_d   = 1'b0;
                    remaining_d = num_terms;
                    if (num_terms != '0) begin
                        state_d = StAccum;
                    end else begin
                        state_d = StDone;
                    end
                end
                // A product seen alongside start still arrived before the run began.
                if (prod_valid) begin
                    dropped_d = 1'b1;
                end
            end

            StAccum: begin
                if (prod_valid) begin
                    acc_d       = sum;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (sum_ovf) begin
                        overflow_d = 1'b1;
                    end
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                // start is deliberately not looked at here, even on the handshake cycle.
                if (acc_ready) begin
                    state_d = StIdle;
                end
                if (prod_valid) begin
                    dropped_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset discards any partial sum
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
        end
    end

    // Outputs come straight from registers, so nothing combinational reaches them
    always_comb begin
        busy      = (state_q != StIdle);
        acc_valid = (state_q == StDone);
        acc_out   = acc_q;
        overflow  = overflow_q;
        dropped   = dropped_q;
    end

endmodule
